// File: rtl/random_word_packer.sv
// random_word_packer: packs RATE-bit entropy chunks into WORD-bit words
// and queues them in a DEPTH-entry FIFO for the consumer.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_data, in_valid    chunk from the sponge source (held while valid)
//   in_received          one-cycle acknowledge of an accepted chunk
//   out_word, out_valid  FIFO head word, FIFO not empty
//   out_ready            consumer pop (transfer when valid && ready)
//   health_fail          sticky repetition-test failure
//
// Optional feature: define RNG_HEALTHTEST_EN to enable the repetition
// count health test; otherwise health_fail is tied low.

module random_word_packer #(
    parameter int RATE      = 8,
    parameter int CHUNKS    = 4,
    parameter int DEPTH     = 4,
    parameter int REP_LIMIT = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RATE-1:0]        in_data,
    input  logic                   in_valid,
    output logic                   in_received,
    output logic [RATE*CHUNKS-1:0] out_word,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   health_fail
);

    localparam int WORD = RATE * CHUNKS;
    localparam int CW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] LAST    = CW'(CHUNKS - 1);
    localparam logic [AW:0]   FULL_AT = (AW + 1)'(DEPTH);

    typedef enum logic {
        ACCEPT,
        GAP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0]   cnt_q;
    logic [WORD-1:0] asm_q;
    logic [WORD-1:0] asm_d;

    logic [WORD-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     fill;

    logic full;
    logic pop;
    logic push;
    logic last;
    logic can_take;
    logic accept;
    logic trip;
    logic blocked;

    assign full      = (fill == FULL_AT);
    assign out_valid = (fill != '0);
    assign pop       = out_valid && out_ready;
    assign last      = (cnt_q == LAST);

    // The final chunk needs a free FIFO slot, which a same-cycle pop
    // provides even when the FIFO is full.
    assign can_take = !(last && full && !pop);

    assign accept = (state_q == ACCEPT) && in_valid && can_take
                    && !blocked && !rst;

    // A chunk that trips the health test never completes a word.
    assign push = accept && last && !trip;

    assign out_word = out_valid ? mem[rd_ptr] : '0;

    // Word under construction with the incoming chunk merged in.
    always_comb begin
        asm_d = asm_q;
        asm_d[int'(cnt_q) * RATE +: RATE] = in_data;
    end

    // Acceptor FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_received = 1'b0;
        unique case (state_q)
            ACCEPT: begin
                if (accept) begin
                    in_received = 1'b1;
                    state_d     = GAP;
                end
            end
            GAP: begin
                state_d = ACCEPT;
            end
            default: begin
                state_d = ACCEPT;
            end
        endcase
    end

    // Chunk assembler
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else if (accept) begin
            if (last || trip) begin
                cnt_q <= '0;
                asm_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
                asm_q <= asm_d;
            end
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   fill <= fill + (AW + 1)'(1);
                2'b01:   fill <= fill - (AW + 1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Storage needs no reset; fill gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= asm_d;
        end
    end

`ifdef RNG_HEALTHTEST_EN
    localparam int RW = $clog2(REP_LIMIT + 1);

    logic [RATE-1:0] prev_q;
    logic [RW-1:0]   run_q;
    logic [RW-1:0]   run_d;
    logic            fail_q;

    // A run restarts at 1 on the first chunk or on any change.
    always_comb begin
        run_d = RW'(1);
        if (run_q != '0 && in_data == prev_q) begin
            run_d = run_q + RW'(1);
        end
    end

    assign trip        = accept && (run_d == RW'(REP_LIMIT));
    assign blocked     = fail_q;
    assign health_fail = fail_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            run_q  <= '0;
            fail_q <= 1'b0;
        end else if (accept) begin
            prev_q <= in_data;
            run_q  <= run_d;
            if (trip) begin
                fail_q <= 1'b1;
            end
        end
    end
`else
    assign trip        = 1'b0;
    assign blocked     = 1'b0;
    assign health_fail = 1'b0;
`endif

endmodule
